regfile_scoreboard: RTL and testbench

//  Decode-stage register file and hazard scoreboard; the receiving end of the writeback interface
//  (reg_load / reg_dest / reg_data). Holds R0-R7 and serves two combinational read ports to decode.

---
 rtl/lc3b_types.sv | 8 +
 rtl/sb_counter.sv | 32 +++
 rtl/regfile_scoreboard.sv | 103 ++++++++++
 tb/tb_regfile_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus register-file and scoreboard sizing constants.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  localparam int LC3B_NUM_REGS = 8;
  localparam int LC3B_PEND_W   = 2;
endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for a single register.
// Latency: count updates on the next clock edge. No backpressure; full/underflow are combinational flags.
// The owner keeps inc low while full, so saturation here only protects against wrap.
module sb_counter
  import lc3b_types::*;
#(
  parameter int W = LC3B_PEND_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  assign full      = &count;
  assign underflow = dec && (count == '0);

  // Simultaneous inc and dec cancel; each direction alone saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// R0-R7 register file with two combinational read ports and a per-register pending-write scoreboard.
// Latency: reads 0 cycles, writes visible the next cycle. Stall refuses issue on RAW hazards or a full counter.
// REGFILE_BYPASS_EN selects write-through reads and same-cycle release of a hazard resolved by writeback.
module regfile_scoreboard
  import lc3b_types::*;
#(
  parameter int       PEND_W    = LC3B_PEND_W,
  parameter lc3b_word RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_reg_load,
  input  logic [2:0]  wb_reg_dest,
  input  logic [15:0] wb_reg_data,
  input  logic [2:0]  id_sr1,
  input  logic [2:0]  id_sr2,
  input  logic        id_sr1_used,
  input  logic        id_sr2_used,
  input  logic [2:0]  id_dest,
  input  logic        id_dest_vld,
  input  logic        id_issue,
  output logic [15:0] id_sr1_data,
  output logic [15:0] id_sr2_data,
  output logic        stall,
  output logic        sb_err
);

  lc3b_word          regs [LC3B_NUM_REGS];
  logic [PEND_W-1:0] cnt  [LC3B_NUM_REGS];

  logic [LC3B_NUM_REGS-1:0] inc_vec;
  logic [LC3B_NUM_REGS-1:0] dec_vec;
  logic [LC3B_NUM_REGS-1:0] full_vec;
  logic [LC3B_NUM_REGS-1:0] uflow_vec;

  logic wb_hit1, wb_hit2, wb_hit_dest;
  logic resolve1, resolve2;
  logic hazard1, hazard2, saturate;
  logic issue_ok;
  logic sb_err_q;

  assign wb_hit1     = wb_reg_load && (wb_reg_dest == id_sr1);
  assign wb_hit2     = wb_reg_load && (wb_reg_dest == id_sr2);
  assign wb_hit_dest = wb_reg_load && (wb_reg_dest == id_dest);

`ifdef REGFILE_BYPASS_EN
  // The last outstanding write arriving now satisfies the reader through the bypass.
  assign resolve1    = wb_hit1 && (cnt[id_sr1] == PEND_W'(1));
  assign resolve2    = wb_hit2 && (cnt[id_sr2] == PEND_W'(1));
  assign id_sr1_data = wb_hit1 ? wb_reg_data : regs[id_sr1];
  assign id_sr2_data = wb_hit2 ? wb_reg_data : regs[id_sr2];
`else
  assign resolve1    = 1'b0;
  assign resolve2    = 1'b0;
  assign id_sr1_data = regs[id_sr1];
  assign id_sr2_data = regs[id_sr2];
`endif

  assign hazard1  = id_sr1_used && (cnt[id_sr1] != '0) && !resolve1;
  assign hazard2  = id_sr2_used && (cnt[id_sr2] != '0) && !resolve2;
  // A full counter can still accept a new issue when a writeback frees a slot this cycle.
  assign saturate = id_dest_vld && full_vec[id_dest] && !wb_hit_dest;
  assign stall    = hazard1 || hazard2 || saturate;
  assign issue_ok = id_issue && !stall;

  for (genvar i = 0; i < LC3B_NUM_REGS; i++) begin : g_cnt
    assign inc_vec[i] = issue_ok && id_dest_vld && (id_dest == lc3b_reg'(i));
    assign dec_vec[i] = wb_reg_load && (wb_reg_dest == lc3b_reg'(i));

    sb_counter #(
      .W (PEND_W)
    ) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .count     (cnt[i]),
      .full      (full_vec[i]),
      .underflow (uflow_vec[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < LC3B_NUM_REGS; r++) begin
        regs[r] <= RESET_VAL;
      end
    end else if (wb_reg_load) begin
      regs[wb_reg_dest] <= wb_reg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_err_q <= 1'b0;
    end else if (|uflow_vec) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations, a negedge monitor compares DUT outputs.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int PMAX = 3;

  typedef struct {
    bit          rst_n;
    bit          wb_load;
    int          wb_dest;
    logic [15:0] wb_data;
    int          sr1, sr2;
    bit          u1, u2;
    int          dest;
    bit          dvld;
    bit          issue;
  } stim_t;

  typedef struct {
    bit          stall;
    logic [15:0] d1, d2;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_reg_load;
  logic [2:0]  wb_reg_dest;
  logic [15:0] wb_reg_data;
  logic [2:0]  id_sr1, id_sr2, id_dest;
  logic        id_sr1_used, id_sr2_used, id_dest_vld, id_issue;
  logic [15:0] id_sr1_data, id_sr2_data;
  logic        stall, sb_err;

  regfile_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb_reg_load (wb_reg_load),
    .wb_reg_dest (wb_reg_dest),
    .wb_reg_data (wb_reg_data),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_sr1_used (id_sr1_used),
    .id_sr2_used (id_sr2_used),
    .id_dest     (id_dest),
    .id_dest_vld (id_dest_vld),
    .id_issue    (id_issue),
    .id_sr1_data (id_sr1_data),
    .id_sr2_data (id_sr2_data),
    .stall       (stall),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register values, outstanding writes per register, sticky error.
  logic [15:0] m_regs [8];
  int          m_pend [8];
  bit          m_err;
  exp_t        exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",   {15'd0, stall},  {15'd0, e.stall});
        chk("sr1_data", id_sr1_data, e.d1);
        chk("sr2_data", id_sr2_data, e.d2);
        chk("sb_err",  {15'd0, sb_err}, {15'd0, e.err});
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.wb_load = 1'b0; s.wb_dest = 0; s.wb_data = 16'h0;
    s.sr1 = 0; s.sr2 = 0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.dest = 0; s.dvld = 1'b0; s.issue = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   wb1, wb2, h1, h2, sat, stl, inc;
    @(posedge clk);
    #2;
    reset_n     = s.rst_n;
    wb_reg_load = s.wb_load;
    wb_reg_dest = 3'(s.wb_dest);
    wb_reg_data = s.wb_data;
    id_sr1      = 3'(s.sr1);
    id_sr2      = 3'(s.sr2);
    id_sr1_used = s.u1;
    id_sr2_used = s.u2;
    id_dest     = 3'(s.dest);
    id_dest_vld = s.dvld;
    id_issue    = s.issue;
    if (!s.rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 16'h0000;
        m_pend[i] = 0;
      end
      m_err = 1'b0;
    end
    wb1 = s.wb_load && (s.wb_dest == s.sr1);
    wb2 = s.wb_load && (s.wb_dest == s.sr2);
    h1  = s.u1 && (m_pend[s.sr1] != 0) && !(BYP && wb1 && m_pend[s.sr1] == 1);
    h2  = s.u2 && (m_pend[s.sr2] != 0) && !(BYP && wb2 && m_pend[s.sr2] == 1);
    sat = s.dvld && (m_pend[s.dest] == PMAX) && !(s.wb_load && s.wb_dest == s.dest);
    stl = h1 || h2 || sat;
    e.stall = stl;
    e.d1    = (BYP && wb1) ? s.wb_data : m_regs[s.sr1];
    e.d2    = (BYP && wb2) ? s.wb_data : m_regs[s.sr2];
    e.err   = m_err;
    exp_q.push_back(e);
    if (s.rst_n) begin
      inc = s.issue && !stl && s.dvld;
      if (s.wb_load && m_pend[s.wb_dest] == 0) m_err = 1'b1;
      if (s.wb_load) m_regs[s.wb_dest] = s.wb_data;
      if (!(inc && s.wb_load && s.dest == s.wb_dest)) begin
        if (inc && m_pend[s.dest] < PMAX) m_pend[s.dest]++;
        if (s.wb_load && m_pend[s.wb_dest] > 0) m_pend[s.wb_dest]--;
      end
    end
  endtask

  task automatic wb(input int r, input logic [15:0] d);
    stim_t s = idle();
    s.wb_load = 1'b1; s.wb_dest = r; s.wb_data = d;
    apply(s);
  endtask

  task automatic iss(input int r, input bit with_wb, input int wr);
    stim_t s = idle();
    s.issue = 1'b1; s.dvld = 1'b1; s.dest = r;
    s.wb_load = with_wb; s.wb_dest = wr; s.wb_data = 16'(wr * 16'h1111);
    apply(s);
  endtask

  task automatic rd(input int a, input int b);
    stim_t s = idle();
    s.sr1 = a; s.sr2 = b; s.u1 = 1'b1; s.u2 = 1'b1;
    apply(s);
  endtask

  function automatic stim_t rand_stim(input bit allow_uf);
    stim_t s = idle();
    int    pend_list [$];
    for (int i = 0; i < 8; i++) if (m_pend[i] > 0) pend_list.push_back(i);
    s.sr1 = int'($urandom_range(7)); s.sr2 = int'($urandom_range(7));
    s.u1 = 1'($urandom); s.u2 = 1'($urandom);
    s.dest = int'($urandom_range(7)); s.dvld = ($urandom_range(3) != 0);
    s.issue = ($urandom_range(9) < 7);
    s.wb_data = 16'($urandom);
    if (pend_list.size() > 0 && $urandom_range(1) == 1) begin
      s.wb_load = 1'b1;
      s.wb_dest = pend_list[$urandom_range(pend_list.size() - 1)];
    end else if (allow_uf && $urandom_range(29) == 0) begin
      s.wb_load = 1'b1;
      s.wb_dest = int'($urandom_range(7));
    end
    return s;
  endfunction

  initial begin
    stim_t s;
    reset_n = 1'b0; wb_reg_load = 1'b0; wb_reg_dest = 3'd0; wb_reg_data = 16'h0;
    id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
    id_dest = 3'd0; id_dest_vld = 1'b0; id_issue = 1'b0;
    s = idle(); s.rst_n = 1'b0; apply(s);
    rd(0, 7);
    // Write then read back; untouched neighbour still holds reset value.
    wb(3, 16'h1234); rd(3, 4);
    // RAW on R2 resolved by its writeback.
    iss(2, 1'b0, 0);
    s = idle(); s.sr1 = 2; s.u1 = 1'b1; apply(s);
    s.wb_load = 1'b1; s.wb_dest = 2; s.wb_data = 16'h00AA; apply(s);
    s = idle(); s.sr1 = 2; s.u1 = 1'b1; apply(s);
    // Same-register inc and dec cancel.
    iss(4, 1'b0, 0); iss(4, 1'b1, 4); rd(4, 0); wb(4, 16'h4444); rd(4, 4);
    // Saturation on R1, then release via writeback in the issuing cycle.
    iss(1, 1'b0, 0); iss(1, 1'b0, 0); iss(1, 1'b0, 0);
    iss(1, 1'b0, 0); iss(1, 1'b1, 1); iss(1, 1'b0, 0);
    wb(1, 16'hA001); wb(1, 16'hA002); wb(1, 16'hA003); rd(1, 1);
    // Underflow is sticky.
    wb(6, 16'h5555); rd(6, 6); rd(0, 0); rd(6, 3);
    // Random traffic with legal writebacks only.
    for (int n = 0; n < 400; n++) apply(rand_stim(1'b0));
    // Asynchronous reset in the middle of traffic.
    s = rand_stim(1'b0); s.rst_n = 1'b0; apply(s);
    s = idle(); apply(s);
    for (int n = 0; n < 600; n++) apply(rand_stim(1'b1));
    s = rand_stim(1'b0); s.rst_n = 1'b0; apply(s);
    for (int n = 0; n < 200; n++) apply(rand_stim(1'b1));
    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
